myo_spi_responder: RTL

//  SPI slave that answers the myocontrol SPI master the way a muscle motor board does.

---
 rtl/myo_spi_responder_if.sv | 29 ++
 rtl/myo_spi_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/myo_spi_responder_if.sv
// Pin and fabric-side bundle of the myocontrol SPI responder.
// The slave modport is the responder; the master modport is the SPI master plus fabric logic.
interface myo_spi_responder_if #(
    parameter int WORDS = 12
);
    logic                  sck;
    logic                  mosi;
    logic                  ss_n;
    logic                  miso;
    logic                  miso_oe;
    logic [WORDS*16-1:0]   tx_frame;
    logic                  tx_ack;
    logic [15:0]           rx_word;
    logic [4:0]            rx_index;
    logic                  rx_valid;
    logic                  frame_done;
    logic                  frame_error;
    logic                  busy;

    modport slave (
        input  sck, mosi, ss_n, tx_frame,
        output miso, miso_oe, tx_ack, rx_word, rx_index, rx_valid, frame_done, frame_error, busy
    );

    modport master (
        output sck, mosi, ss_n, tx_frame,
        input  miso, miso_oe, tx_ack, rx_word, rx_index, rx_valid, frame_done, frame_error, busy
    );
endinterface

// File: rtl/myo_spi_responder.sv
// SPI mode-0 slave emulating a muscle board: RX words one cycle after the 16th sck rise is seen, no backpressure.
// TX frame captured at ss_n fall; MYO_SPI_CHECKSUM_EN makes the last word a checksum on both directions.
module myo_spi_responder #(
    parameter int WORDS = 12,
    parameter int SYNC  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    myo_spi_responder_if.slave spi
);
    localparam logic [5:0] LP_WORDS = 6'(WORDS);
    localparam logic [5:0] LP_LAST  = 6'(WORDS - 1);

    typedef enum logic [1:0] {ST_WAIT_IDLE, ST_IDLE, ST_SHIFT} state_t;

    state_t          r_state, w_state_nxt;
    logic [SYNC-1:0] r_sck_s, r_mosi_s, r_ss_s;
    logic            r_sck_d, r_ss_d;
    logic            w_sck, w_mosi, w_ss;
    logic            w_start, w_end, w_rise_act, w_fall_act;
    logic [15:0]     r_tx_mem [WORDS];
    logic [15:0]     w_cur_word, w_rx_next;
    logic            w_tx_bit;
    logic [15:0]     r_rx_shift;
    logic [3:0]      r_bit_cnt;
    logic [5:0]      r_word_cnt;
    logic            r_miso, r_miso_oe, r_busy, r_tx_ack;
    logic [15:0]     r_rx_word;
    logic [4:0]      r_rx_index;
    logic            r_rx_valid, r_frame_done, r_frame_error;
    logic            r_cks_bad;
`ifdef MYO_SPI_CHECKSUM_EN
    logic [15:0]     w_tx_sum, r_rx_sum;
`endif

    assign w_sck  = r_sck_s[SYNC-1];
    assign w_mosi = r_mosi_s[SYNC-1];
    assign w_ss   = r_ss_s[SYNC-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sck_s  <= '0;
            r_mosi_s <= '0;
            r_ss_s   <= '0;
            r_sck_d  <= 1'b0;
            r_ss_d   <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[SYNC-2:0], spi.sck};
            r_mosi_s <= {r_mosi_s[SYNC-2:0], spi.mosi};
            r_ss_s   <= {r_ss_s[SYNC-2:0], spi.ss_n};
            r_sck_d  <= w_sck;
            r_ss_d   <= w_ss;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_WAIT_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ss_n rise takes priority over any sck edge seen in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_rise_act  = 1'b0;
        w_fall_act  = 1'b0;
        case (r_state)
            ST_WAIT_IDLE: if (w_ss) w_state_nxt = ST_IDLE;
            ST_IDLE: if (!w_ss && r_ss_d) begin
                w_state_nxt = ST_SHIFT;
                w_start     = 1'b1;
            end
            ST_SHIFT: begin
                if (w_ss && !r_ss_d) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                end else begin
                    w_rise_act = w_sck && !r_sck_d;
                    w_fall_act = !w_sck && r_sck_d;
                end
            end
            default: w_state_nxt = ST_WAIT_IDLE;
        endcase
    end

    // Out-of-range word counts select zero, which holds miso low past the frame
    always_comb begin
        w_cur_word = '0;
        for (int k = 0; k < WORDS; k++)
            if (r_word_cnt == 6'(k)) w_cur_word = r_tx_mem[k];
    end

    assign w_tx_bit  = w_cur_word[4'd15 - r_bit_cnt];
    assign w_rx_next = {r_rx_shift[14:0], w_mosi};

`ifdef MYO_SPI_CHECKSUM_EN
    always_comb begin
        w_tx_sum = '0;
        for (int k = 0; k < WORDS - 1; k++) w_tx_sum = w_tx_sum + spi.tx_frame[16*k +: 16];
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < WORDS; k++) r_tx_mem[k] <= '0;
            r_rx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_ack      <= 1'b0;
            r_rx_word     <= '0;
            r_rx_index    <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
            r_cks_bad     <= 1'b0;
`ifdef MYO_SPI_CHECKSUM_EN
            r_rx_sum      <= '0;
`endif
        end else begin
            r_tx_ack      <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
            if (w_start) begin
                for (int k = 0; k < WORDS; k++) r_tx_mem[k] <= spi.tx_frame[16*k +: 16];
`ifdef MYO_SPI_CHECKSUM_EN
                r_tx_mem[WORDS-1] <= w_tx_sum;
                r_rx_sum          <= '0;
`endif
                r_tx_ack   <= 1'b1;
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
                r_cks_bad  <= 1'b0;
                r_miso     <= spi.tx_frame[15];
                r_miso_oe  <= 1'b1;
                r_busy     <= 1'b1;
            end
            if (w_rise_act) begin
                r_rx_shift <= w_rx_next;
                if (r_bit_cnt == 4'd15) begin
                    r_bit_cnt <= '0;
                    if (r_word_cnt < LP_WORDS) begin
                        r_rx_word  <= w_rx_next;
                        r_rx_index <= r_word_cnt[4:0];
                        r_rx_valid <= 1'b1;
                    end
`ifdef MYO_SPI_CHECKSUM_EN
                    if (r_word_cnt < LP_LAST)
                        r_rx_sum <= r_rx_sum + w_rx_next;
                    else if (r_word_cnt == LP_LAST)
                        r_cks_bad <= (w_rx_next != r_rx_sum);
`endif
                    if (r_word_cnt != 6'd63) r_word_cnt <= r_word_cnt + 6'd1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
            if (w_fall_act) r_miso <= w_tx_bit;
            if (w_end) begin
                r_frame_done  <= 1'b1;
                r_frame_error <= (r_bit_cnt != 4'd0) || (r_word_cnt != LP_WORDS) || r_cks_bad;
                r_miso        <= 1'b0;
                r_miso_oe     <= 1'b0;
                r_busy        <= 1'b0;
            end
        end
    end

    assign spi.miso        = r_miso;
    assign spi.miso_oe     = r_miso_oe;
    assign spi.busy        = r_busy;
    assign spi.tx_ack      = r_tx_ack;
    assign spi.rx_word     = r_rx_word;
    assign spi.rx_index    = r_rx_index;
    assign spi.rx_valid    = r_rx_valid;
    assign spi.frame_done  = r_frame_done;
    assign spi.frame_error = r_frame_error;
endmodule
